// File: rtl/vdp_pkg.sv
// Shared encodings for the VDP CPU port: widths, modes, status bits, register indices, FSM states.
package vdp_pkg;

  localparam int unsigned ADDR_W = 14;
  localparam int unsigned DATA_W = 8;

  localparam logic [1:0] MODE_TEXT = 2'd0;
  localparam logic [1:0] MODE_G1   = 2'd1;
  localparam logic [1:0] MODE_G2   = 2'd2;
  localparam logic [1:0] MODE_MC   = 2'd3;

  localparam int unsigned STAT_F  = 7;
  localparam int unsigned STAT_S5 = 6;
  localparam int unsigned STAT_C  = 5;

  localparam logic [2:0] REG_MODE0  = 3'd0;
  localparam logic [2:0] REG_MODE1  = 3'd1;
  localparam logic [2:0] REG_NAME   = 3'd2;
  localparam logic [2:0] REG_COLOR  = 3'd3;
  localparam logic [2:0] REG_FONT   = 3'd4;
  localparam logic [2:0] REG_SATTR  = 3'd5;
  localparam logic [2:0] REG_SPAT   = 3'd6;
  localparam logic [2:0] REG_COLORS = 3'd7;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_PREFETCH = 2'd1;
  localparam logic [1:0] ST_CAPTURE  = 2'd2;

  // Mode priority: M1 (text) beats M2 (multicolor) beats M3 (graphics II).
  function automatic logic [1:0] decode_mode(input logic m1, input logic m2, input logic m3);
    if (m1)      return MODE_TEXT;
    else if (m2) return MODE_MC;
    else if (m3) return MODE_G2;
    else         return MODE_G1;
  endfunction

endpackage

// File: rtl/vdp_cpu_port_if.sv
// CPU I/O strobes plus the VRAM (vga_*) port; slave is the VDP side.
interface vdp_cpu_port_if;
  import vdp_pkg::*;

  logic              cpu_port;
  logic              cpu_wr;
  logic              cpu_rd;
  logic [DATA_W-1:0] cpu_din;
  logic [DATA_W-1:0] cpu_dout;
  logic [ADDR_W-1:0] vga_addr;
  logic [DATA_W-1:0] vga_din;
  logic [DATA_W-1:0] vga_dout;
  logic              vga_wr;
  logic              vga_rd;

  modport master (
    output cpu_port, cpu_wr, cpu_rd, cpu_din, vga_dout,
    input  cpu_dout, vga_addr, vga_din, vga_wr, vga_rd
  );

  modport slave (
    input  cpu_port, cpu_wr, cpu_rd, cpu_din, vga_dout,
    output cpu_dout, vga_addr, vga_din, vga_wr, vga_rd
  );

endinterface

// File: rtl/vdp_regs.sv
// VDP registers R0-R7 and the display-configuration decode derived from them.
module vdp_regs
  import vdp_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [2:0]        wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  output logic [1:0]        mode,
  output logic [ADDR_W-1:0] name_table_addr,
  output logic [ADDR_W-1:0] color_table_addr,
  output logic [ADDR_W-1:0] font_addr,
  output logic [ADDR_W-1:0] sprite_attr_addr,
  output logic [ADDR_W-1:0] sprite_pattern_table_addr,
  output logic              video_on,
  output logic              vert_retrace_int,
  output logic              sprite_large,
  output logic              sprite_enlarged,
  output logic [3:0]        text_color,
  output logic [3:0]        back_color
);

  logic [DATA_W-1:0] regs [8];
  logic              is_g2;
  logic              unused_bits;

  // Register file write port
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[wr_idx] <= wr_data;
    end
  end

  // Mode and table base decode; graphics II uses coarse color/pattern bases
  always_comb begin
    mode             = decode_mode(regs[REG_MODE1][4], regs[REG_MODE1][3], regs[REG_MODE0][1]);
    is_g2            = (mode == MODE_G2);
    name_table_addr  = {regs[REG_NAME][3:0], 10'b0};
    color_table_addr = is_g2 ? {regs[REG_COLOR][7], 13'b0} : {regs[REG_COLOR], 6'b0};
    font_addr        = is_g2 ? {regs[REG_FONT][2], 13'b0} : {regs[REG_FONT][2:0], 11'b0};
    sprite_attr_addr = {regs[REG_SATTR][6:0], 7'b0};
    sprite_pattern_table_addr = {regs[REG_SPAT][2:0], 11'b0};
    video_on         = regs[REG_MODE1][6];
    vert_retrace_int = regs[REG_MODE1][5];
    sprite_large     = regs[REG_MODE1][1];
    sprite_enlarged  = regs[REG_MODE1][0];
    text_color       = regs[REG_COLORS][7:4];
    back_color       = regs[REG_COLORS][3:0];
  end

  // Register bits with no display function
  assign unused_bits = ^{regs[REG_MODE0][7:2], regs[REG_MODE0][0], regs[REG_MODE1][7],
                         regs[REG_MODE1][2], regs[REG_NAME][7:4], regs[REG_FONT][7:3],
                         regs[REG_SATTR][7], regs[REG_SPAT][7:3]};

endmodule

// File: rtl/vdp_cpu_port.sv
// CPU-side VDP port: control/data decode, VRAM address counter, prefetch, status and interrupt.
module vdp_cpu_port
  import vdp_pkg::*;
#(
  parameter int unsigned HOLDOFF = 3
) (
  input  logic              clk,
  input  logic              reset,
  vdp_cpu_port_if.slave     bus,
  output logic [1:0]        mode,
  output logic [ADDR_W-1:0] name_table_addr,
  output logic [ADDR_W-1:0] color_table_addr,
  output logic [ADDR_W-1:0] font_addr,
  output logic [ADDR_W-1:0] sprite_attr_addr,
  output logic [ADDR_W-1:0] sprite_pattern_table_addr,
  output logic              video_on,
  output logic              vert_retrace_int,
  output logic              sprite_large,
  output logic              sprite_enlarged,
  output logic [3:0]        text_color,
  output logic [3:0]        back_color,
  input  logic              interrupt_flag,
  input  logic              sprite_collision,
  input  logic              too_many_sprites,
  input  logic [4:0]        sprite5,
  output logic              n_int,
  output logic              overrun
);

  localparam int unsigned CNT_W = $clog2(HOLDOFF + 2);

  logic [1:0]        state, state_nxt;
  logic [ADDR_W-1:0] addr, addr_nxt, vga_addr_nxt;
  logic [DATA_W-1:0] latch, latch_nxt, rbuf, rbuf_nxt;
  logic [DATA_W-1:0] cpu_dout_nxt, vga_din_nxt, stat_byte;
  logic              second, second_nxt, vga_wr_nxt, vga_rd_nxt;
  logic              f_flag, s5_flag, c_flag, f_nxt, s5_nxt, c_nxt, int_q;
  logic [CNT_W-1:0]  gap_cnt, gap_cnt_nxt;
  logic              overrun_nxt, n_int_nxt, stat_clr, reg_wr;
  logic              strobe, accept, f_set;

  assign strobe = bus.cpu_wr | bus.cpu_rd;
  assign accept = strobe && (state == ST_IDLE) && (gap_cnt >= CNT_W'(HOLDOFF));
  assign f_set  = interrupt_flag & ~int_q;

  vdp_regs u_regs (
    .clk                       (clk),
    .reset                     (reset),
    .wr_en                     (reg_wr),
    .wr_idx                    (bus.cpu_din[2:0]),
    .wr_data                   (latch),
    .mode                      (mode),
    .name_table_addr           (name_table_addr),
    .color_table_addr          (color_table_addr),
    .font_addr                 (font_addr),
    .sprite_attr_addr          (sprite_attr_addr),
    .sprite_pattern_table_addr (sprite_pattern_table_addr),
    .video_on                  (video_on),
    .vert_retrace_int          (vert_retrace_int),
    .sprite_large              (sprite_large),
    .sprite_enlarged           (sprite_enlarged),
    .text_color                (text_color),
    .back_color                (back_color)
  );

  // Next-state: strobe decode in IDLE, prefetch sequencing, status flags and interrupt
  always_comb begin
    state_nxt    = state;
    addr_nxt     = addr;
    latch_nxt    = latch;
    rbuf_nxt     = rbuf;
    second_nxt   = second;
    cpu_dout_nxt = bus.cpu_dout;
    vga_addr_nxt = bus.vga_addr;
    vga_din_nxt  = bus.vga_din;
    vga_wr_nxt   = 1'b0;
    vga_rd_nxt   = 1'b0;
    reg_wr       = 1'b0;
    stat_clr     = 1'b0;
    overrun_nxt  = overrun | (strobe & ~accept);
    gap_cnt_nxt  = (gap_cnt >= CNT_W'(HOLDOFF)) ? gap_cnt : gap_cnt + CNT_W'(1);

    stat_byte          = {3'b000, sprite5};
    stat_byte[STAT_F]  = f_flag;
    stat_byte[STAT_S5] = s5_flag;
    stat_byte[STAT_C]  = c_flag;

    case (state)
      ST_PREFETCH: state_nxt = ST_CAPTURE;
      ST_CAPTURE: begin
        rbuf_nxt  = bus.vga_dout;
        addr_nxt  = addr + ADDR_W'(1);
        state_nxt = ST_IDLE;
      end
      ST_IDLE: ;
      default: state_nxt = ST_IDLE;
    endcase

    if (accept) begin
      gap_cnt_nxt = CNT_W'(1);
      second_nxt  = 1'b0;
      if (bus.cpu_port && bus.cpu_wr) begin
        if (!second) begin
          latch_nxt  = bus.cpu_din;
          second_nxt = 1'b1;
        end else if (bus.cpu_din[7]) begin
          reg_wr = 1'b1;
        end else begin
          addr_nxt = {bus.cpu_din[5:0], latch};
          if (!bus.cpu_din[6]) begin
            vga_addr_nxt = {bus.cpu_din[5:0], latch};
            vga_rd_nxt   = 1'b1;
            state_nxt    = ST_PREFETCH;
          end
        end
      end else if (bus.cpu_port) begin
        cpu_dout_nxt = stat_byte;
        stat_clr     = 1'b1;
      end else if (bus.cpu_wr) begin
        vga_addr_nxt = addr;
        vga_din_nxt  = bus.cpu_din;
        vga_wr_nxt   = 1'b1;
        rbuf_nxt     = bus.cpu_din;
        addr_nxt     = addr + ADDR_W'(1);
      end else begin
        cpu_dout_nxt = rbuf;
        vga_addr_nxt = addr;
        vga_rd_nxt   = 1'b1;
        state_nxt    = ST_PREFETCH;
      end
    end

    f_nxt  = f_set | (f_flag & ~stat_clr);
    s5_nxt = too_many_sprites | (s5_flag & ~stat_clr);
    c_nxt  = sprite_collision | (c_flag & ~stat_clr);
    // A status read releases the line at once unless a new frame edge lands with it
    n_int_nxt = ~(f_flag & vert_retrace_int & (~stat_clr | f_set));
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      addr         <= '0;
      latch        <= '0;
      rbuf         <= '0;
      second       <= 1'b0;
      f_flag       <= 1'b0;
      s5_flag      <= 1'b0;
      c_flag       <= 1'b0;
      int_q        <= 1'b0;
      gap_cnt      <= CNT_W'(HOLDOFF);
      overrun      <= 1'b0;
      n_int        <= 1'b1;
      bus.cpu_dout <= '0;
      bus.vga_addr <= '0;
      bus.vga_din  <= '0;
      bus.vga_wr   <= 1'b0;
      bus.vga_rd   <= 1'b0;
    end else begin
      state        <= state_nxt;
      addr         <= addr_nxt;
      latch        <= latch_nxt;
      rbuf         <= rbuf_nxt;
      second       <= second_nxt;
      f_flag       <= f_nxt;
      s5_flag      <= s5_nxt;
      c_flag       <= c_nxt;
      int_q        <= interrupt_flag;
      gap_cnt      <= gap_cnt_nxt;
      overrun      <= overrun_nxt;
      n_int        <= n_int_nxt;
      bus.cpu_dout <= cpu_dout_nxt;
      bus.vga_addr <= vga_addr_nxt;
      bus.vga_din  <= vga_din_nxt;
      bus.vga_wr   <= vga_wr_nxt;
      bus.vga_rd   <= vga_rd_nxt;
    end
  end

endmodule

// File: tb/tb_vdp_cpu_port.sv
// Scenario bench for vdp_cpu_port with a VRAM model and a bus-transaction scoreboard.
module tb_vdp_cpu_port;
  import vdp_pkg::*;

  typedef struct packed {
    logic        wr;
    logic [13:0] addr;
    logic [7:0]  data;
  } bus_op_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  mode;
  logic [13:0] name_table_addr, color_table_addr, font_addr, sprite_attr_addr, sprite_pattern_table_addr;
  logic        video_on, vert_retrace_int, sprite_large, sprite_enlarged;
  logic [3:0]  text_color, back_color;
  logic        interrupt_flag, sprite_collision, too_many_sprites;
  logic [4:0]  sprite5;
  logic        n_int, overrun;

  int vectors = 0;
  int miscompares = 0;
  bus_op_t exp_q[$];
  logic [7:0] mem [0:16383];

  vdp_cpu_port_if bus();

  vdp_cpu_port #(.HOLDOFF(3)) dut (
    .clk                       (clk),
    .reset                     (reset),
    .bus                       (bus),
    .mode                      (mode),
    .name_table_addr           (name_table_addr),
    .color_table_addr          (color_table_addr),
    .font_addr                 (font_addr),
    .sprite_attr_addr          (sprite_attr_addr),
    .sprite_pattern_table_addr (sprite_pattern_table_addr),
    .video_on                  (video_on),
    .vert_retrace_int          (vert_retrace_int),
    .sprite_large              (sprite_large),
    .sprite_enlarged           (sprite_enlarged),
    .text_color                (text_color),
    .back_color                (back_color),
    .interrupt_flag            (interrupt_flag),
    .sprite_collision          (sprite_collision),
    .too_many_sprites          (too_many_sprites),
    .sprite5                   (sprite5),
    .n_int                     (n_int),
    .overrun                   (overrun)
  );

  always #5 clk = ~clk;

  // VRAM: read data appears the cycle after vga_rd
  always @(posedge clk) begin
    if (bus.vga_wr) mem[bus.vga_addr] <= bus.vga_din;
    if (bus.vga_rd) bus.vga_dout <= mem[bus.vga_addr];
  end

  // Advance to the next falling edge and score any VRAM transaction seen there
  task automatic tick();
    bus_op_t got, exp;
    @(negedge clk);
    if (bus.vga_wr || bus.vga_rd) begin
      got.wr   = bus.vga_wr;
      got.addr = bus.vga_addr;
      got.data = bus.vga_wr ? bus.vga_din : 8'h00;
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL vga_unexpected: got wr=%0b addr=%h data=%h, required no transaction", got.wr, got.addr, got.data);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin
          miscompares++;
          $display("FAIL vga_op: got wr=%0b addr=%h data=%h, required wr=%0b addr=%h data=%h",
                   got.wr, got.addr, got.data, exp.wr, exp.addr, exp.data);
        end
      end
    end
  endtask

  // One-cycle CPU strobe followed by gap idle cycles
  task automatic access(input logic port, input logic wr, input logic [7:0] din, input int gap);
    bus.cpu_port = port;
    bus.cpu_wr   = wr;
    bus.cpu_rd   = ~wr;
    bus.cpu_din  = din;
    tick();
    bus.cpu_wr = 1'b0;
    bus.cpu_rd = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic reg_write(input logic [2:0] idx, input logic [7:0] val);
    access(1'b1, 1'b1, val, 2);
    access(1'b1, 1'b1, {5'b10000, idx}, 2);
  endtask

  task automatic push_op(input logic wr, input logic [13:0] a, input logic [7:0] d);
    bus_op_t op;
    op.wr = wr; op.addr = a; op.data = d;
    exp_q.push_back(op);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    vectors++;
    if ({bus.vga_wr, bus.vga_rd, n_int, overrun} !== 4'b0010) begin
      miscompares++;
      $display("FAIL reset_ctl: wr/rd/n_int/overrun=%b required 0010", {bus.vga_wr, bus.vga_rd, n_int, overrun});
    end
    vectors++;
    if (mode !== MODE_G1) begin miscompares++; $display("FAIL reset_mode: got %0d required 1", mode); end
    vectors++;
    if ({name_table_addr, color_table_addr, font_addr, sprite_attr_addr, sprite_pattern_table_addr} !== 70'd0) begin
      miscompares++;
      $display("FAIL reset_addrs: got %h %h %h %h %h required all 0", name_table_addr, color_table_addr,
               font_addr, sprite_attr_addr, sprite_pattern_table_addr);
    end
    vectors++;
    if ({video_on, vert_retrace_int, sprite_large, sprite_enlarged, text_color, back_color, bus.cpu_dout} !== 20'd0) begin
      miscompares++;
      $display("FAIL reset_fields: got %b %h required 0", {video_on, vert_retrace_int, sprite_large, sprite_enlarged},
               {text_color, back_color, bus.cpu_dout});
    end
    access(1'b1, 1'b0, 8'h00, 2);
    vectors++;
    if (bus.cpu_dout !== 8'h00) begin miscompares++; $display("FAIL reset_status: got %h required 00", bus.cpu_dout); end
  endtask

  task automatic test_reg_write();
    logic [7:0] r1v [4];
    logic [1:0] em [4];
    r1v = '{8'hE2, 8'hEA, 8'hF2, 8'hFA};
    em  = '{MODE_G2, MODE_MC, MODE_TEXT, MODE_TEXT};
    access(1'b1, 1'b1, 8'hE2, 2);
    access(1'b1, 1'b1, 8'h81, 2);
    vectors++;
    if ({video_on, vert_retrace_int, sprite_large, sprite_enlarged, mode} !== 6'b1110_01) begin
      miscompares++;
      $display("FAIL r1_fields: got %b required 111001", {video_on, vert_retrace_int, sprite_large, sprite_enlarged, mode});
    end
    reg_write(3'd2, 8'h0F); reg_write(3'd3, 8'hFF); reg_write(3'd4, 8'h07);
    reg_write(3'd5, 8'h7F); reg_write(3'd6, 8'h07); reg_write(3'd7, 8'hF4);
    vectors++;
    if ({name_table_addr, color_table_addr, font_addr, sprite_attr_addr, sprite_pattern_table_addr}
        !== {14'h3C00, 14'h3FC0, 14'h3800, 14'h3F80, 14'h3800}) begin
      miscompares++;
      $display("FAIL table_addrs: got %h %h %h %h %h required 3c00 3fc0 3800 3f80 3800", name_table_addr,
               color_table_addr, font_addr, sprite_attr_addr, sprite_pattern_table_addr);
    end
    vectors++;
    if ({text_color, back_color} !== 8'hF4) begin miscompares++; $display("FAIL colors: got %h required f4", {text_color, back_color}); end
    reg_write(3'd0, 8'h02);
    vectors++;
    if ({mode, color_table_addr, font_addr} !== {MODE_G2, 14'h2000, 14'h2000}) begin
      miscompares++;
      $display("FAIL g2_addrs: mode=%0d color=%h font=%h required 2 2000 2000", mode, color_table_addr, font_addr);
    end
    for (int i = 0; i < 4; i++) begin
      reg_write(3'd1, r1v[i]);
      vectors++;
      if (mode !== em[i]) begin miscompares++; $display("FAIL mode_r1_%h: got %0d required %0d", r1v[i], mode, em[i]); end
    end
    reg_write(3'd0, 8'h00);
    reg_write(3'd1, 8'hE2);
    vectors++;
    if (mode !== MODE_G1) begin miscompares++; $display("FAIL mode_restore: got %0d required 1", mode); end
  endtask

  task automatic test_vram_write();
    access(1'b1, 1'b1, 8'h00, 2);
    access(1'b1, 1'b1, 8'h58, 2);
    push_op(1'b1, 14'h1800, 8'h41); access(1'b0, 1'b1, 8'h41, 2);
    push_op(1'b1, 14'h1801, 8'h42); access(1'b0, 1'b1, 8'h42, 2);
    push_op(1'b0, 14'h1802, 8'h00); access(1'b0, 1'b0, 8'h00, 2);
    vectors++;
    if (bus.cpu_dout !== 8'h42) begin miscompares++; $display("FAIL write_rbuf: got %h required 42", bus.cpu_dout); end
    vectors++;
    if (exp_q.size() != 0) begin miscompares++; $display("FAIL vram_write_drain: %0d pending required 0", exp_q.size()); end
  endtask

  task automatic test_read_wrap();
    access(1'b1, 1'b1, 8'hFF, 2);
    access(1'b1, 1'b1, 8'h7F, 2);
    push_op(1'b1, 14'h3FFF, 8'h5A); access(1'b0, 1'b1, 8'h5A, 2);
    push_op(1'b1, 14'h0000, 8'h3C); access(1'b0, 1'b1, 8'h3C, 2);
    access(1'b1, 1'b1, 8'hFF, 2);
    push_op(1'b0, 14'h3FFF, 8'h00); access(1'b1, 1'b1, 8'h3F, 2);
    push_op(1'b0, 14'h0000, 8'h00); access(1'b0, 1'b0, 8'h00, 2);
    vectors++;
    if (bus.cpu_dout !== 8'h5A) begin miscompares++; $display("FAIL prefetch_3fff: got %h required 5a", bus.cpu_dout); end
    push_op(1'b0, 14'h0001, 8'h00); access(1'b0, 1'b0, 8'h00, 2);
    vectors++;
    if (bus.cpu_dout !== 8'h3C) begin miscompares++; $display("FAIL prefetch_wrap: got %h required 3c", bus.cpu_dout); end
    vectors++;
    if (exp_q.size() != 0) begin miscompares++; $display("FAIL read_drain: %0d pending required 0", exp_q.size()); end
  endtask

  task automatic test_interrupt();
    interrupt_flag = 1'b1; tick(); interrupt_flag = 1'b0;
    vectors++;
    if (n_int !== 1'b1) begin miscompares++; $display("FAIL int_latency: n_int=%b required 1", n_int); end
    tick();
    vectors++;
    if (n_int !== 1'b0) begin miscompares++; $display("FAIL int_fall: n_int=%b required 0", n_int); end
    tick();
    access(1'b1, 1'b0, 8'h00, 2);
    vectors++;
    if (bus.cpu_dout !== 8'h80) begin miscompares++; $display("FAIL status_f: got %h required 80", bus.cpu_dout); end
    vectors++;
    if (n_int !== 1'b1) begin miscompares++; $display("FAIL int_release: n_int=%b required 1", n_int); end
    access(1'b1, 1'b0, 8'h00, 2);
    vectors++;
    if (bus.cpu_dout !== 8'h00) begin miscompares++; $display("FAIL status_cleared: got %h required 00", bus.cpu_dout); end
    interrupt_flag = 1'b1; tick(); interrupt_flag = 1'b0; repeat (2) tick();
    interrupt_flag = 1'b1; access(1'b1, 1'b0, 8'h00, 0); interrupt_flag = 1'b0; repeat (2) tick();
    vectors++;
    if ({bus.cpu_dout, n_int} !== {8'h80, 1'b0}) begin
      miscompares++;
      $display("FAIL set_wins_read: dout=%h n_int=%b required 80 0", bus.cpu_dout, n_int);
    end
    access(1'b1, 1'b0, 8'h00, 2);
    vectors++;
    if (bus.cpu_dout !== 8'h80) begin miscompares++; $display("FAIL set_wins_kept: got %h required 80", bus.cpu_dout); end
    access(1'b1, 1'b0, 8'h00, 2);
    sprite_collision = 1'b1; too_many_sprites = 1'b1; sprite5 = 5'h15; tick();
    sprite_collision = 1'b0; too_many_sprites = 1'b0; tick();
    access(1'b1, 1'b0, 8'h00, 2);
    vectors++;
    if (bus.cpu_dout !== 8'h75) begin miscompares++; $display("FAIL status_sprite: got %h required 75", bus.cpu_dout); end
    access(1'b1, 1'b0, 8'h00, 2);
    vectors++;
    if (bus.cpu_dout !== 8'h15) begin miscompares++; $display("FAIL status_sprite_clr: got %h required 15", bus.cpu_dout); end
    sprite5 = 5'h00;
  endtask

  task automatic test_latch_reset();
    access(1'b1, 1'b1, 8'h12, 2);
    access(1'b1, 1'b0, 8'h00, 2);
    vectors++;
    if (bus.cpu_dout !== 8'h00) begin miscompares++; $display("FAIL latch_status: got %h required 00", bus.cpu_dout); end
    access(1'b1, 1'b1, 8'h34, 2);
    access(1'b1, 1'b1, 8'h87, 2);
    vectors++;
    if ({text_color, back_color} !== 8'h34) begin miscompares++; $display("FAIL latch_r7: got %h required 34", {text_color, back_color}); end
  endtask

  task automatic test_overrun();
    vectors++;
    if (overrun !== 1'b0) begin miscompares++; $display("FAIL overrun_idle: got %b required 0", overrun); end
    access(1'b1, 1'b1, 8'h00, 2);
    access(1'b1, 1'b1, 8'h50, 2);
    push_op(1'b0, 14'h1000, 8'h00);
    access(1'b0, 1'b0, 8'h00, 0);
    access(1'b0, 1'b0, 8'h00, 2);
    vectors++;
    if (overrun !== 1'b1) begin miscompares++; $display("FAIL overrun_set: got %b required 1", overrun); end
    push_op(1'b0, 14'h1001, 8'h00); access(1'b0, 1'b0, 8'h00, 2);
    vectors++;
    if (exp_q.size() != 0) begin miscompares++; $display("FAIL overrun_drain: %0d pending required 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid_prefetch();
    push_op(1'b0, 14'h1002, 8'h00);
    bus.cpu_port = 1'b0; bus.cpu_rd = 1'b1; tick(); bus.cpu_rd = 1'b0;
    reset = 1'b1; tick(); reset = 1'b0; tick();
    vectors++;
    if ({bus.vga_rd, overrun, n_int, mode} !== {1'b0, 1'b0, 1'b1, MODE_G1}) begin
      miscompares++;
      $display("FAIL mid_reset: rd/overrun/n_int/mode=%b required 00101", {bus.vga_rd, overrun, n_int, mode});
    end
    push_op(1'b0, 14'h0000, 8'h00); access(1'b0, 1'b0, 8'h00, 2);
    vectors++;
    if (bus.cpu_dout !== 8'h00) begin miscompares++; $display("FAIL mid_reset_rbuf: got %h required 00", bus.cpu_dout); end
  endtask

  task automatic test_back_to_back();
    access(1'b1, 1'b1, 8'h00, 2);
    access(1'b1, 1'b1, 8'h40, 2);
    push_op(1'b1, 14'h0000, 8'hAA);
    access(1'b0, 1'b1, 8'hAA, 0);
    access(1'b0, 1'b1, 8'hBB, 2);
    vectors++;
    if (overrun !== 1'b1) begin miscompares++; $display("FAIL holdoff_overrun: got %b required 1", overrun); end
    push_op(1'b1, 14'h0001, 8'hCC); access(1'b0, 1'b1, 8'hCC, 2);
    vectors++;
    if (exp_q.size() != 0) begin miscompares++; $display("FAIL holdoff_drain: %0d pending required 0", exp_q.size()); end
  endtask

  initial begin
    reset            = 1'b1;
    bus.cpu_port     = 1'b0;
    bus.cpu_wr       = 1'b0;
    bus.cpu_rd       = 1'b0;
    bus.cpu_din      = 8'h00;
    interrupt_flag   = 1'b0;
    sprite_collision = 1'b0;
    too_many_sprites = 1'b0;
    sprite5          = 5'h00;
    test_reset();
    test_reg_write();
    test_vram_write();
    test_read_wrap();
    test_interrupt();
    test_latch_reset();
    test_overrun();
    test_reset_mid_prefetch();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
